// File: rtl/mxm_operand_sequencer_pkg.sv
// Shared types and sizing helpers for the MxM operand sequencer slice.
package mxm_pkg;

    localparam int W_DEF = 8;
    localparam int M_DEF = 10;
    localparam int N_DEF = 8;
    localparam int P_DEF = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } seq_state_t;

    // Load address width: covers the larger of the two operand arrays.
    function automatic int addr_w(input int m, input int n, input int p);
        int sz;
        sz = (m * n > n * p) ? m * n : n * p;
        return (sz > 1) ? $clog2(sz) : 1;
    endfunction

    function automatic int idx_w(input int cnt);
        return (cnt > 1) ? $clog2(cnt) : 1;
    endfunction

endpackage

// File: rtl/mxm_operand_sequencer_if.sv
// Load bus and operand stream between the sequencer and its host/consumer.
interface mxm_operand_sequencer_if #(
    parameter int W  = mxm_pkg::W_DEF,
    parameter int AW = mxm_pkg::addr_w(mxm_pkg::M_DEF, mxm_pkg::N_DEF, mxm_pkg::P_DEF)
);
    logic          load_we;
    logic          load_sel;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic          start;
    logic          busy;
    logic          valid;
    logic          first;
    logic          last;
    logic          done;
    logic [W-1:0]  A;
    logic [W-1:0]  X;

    modport master (
        output load_we, load_sel, load_addr, load_data, start,
        input  busy, valid, first, last, done, A, X
    );

    modport slave (
        input  load_we, load_sel, load_addr, load_data, start,
        output busy, valid, first, last, done, A, X
    );
endinterface

// File: rtl/mxm_operand_sequencer_index_counter.sv
// Nested n/m/p index counter: n fastest, then m, then p; wraps to zero after the last triple.
module mxm_index_counter
    import mxm_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF,
    parameter int P = P_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    output logic [idx_w(N)-1:0] n,
    output logic [idx_w(M)-1:0] m,
    output logic [idx_w(P)-1:0] p,
    output logic                last
);
    localparam int NW = idx_w(N);
    localparam int MW = idx_w(M);
    localparam int PW = idx_w(P);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic [PW-1:0] P_LAST = PW'(P - 1);

    logic n_wrap;
    logic m_wrap;

    assign n_wrap = (n == N_LAST);
    assign m_wrap = n_wrap && (m == M_LAST);
    assign last   = m_wrap && (p == P_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= '0;
            m <= '0;
            p <= '0;
        end else if (clr) begin
            n <= '0;
            m <= '0;
            p <= '0;
        end else if (en) begin
            if (n_wrap) begin
                n <= '0;
                if (m_wrap) begin
                    m <= '0;
                    p <= last ? '0 : p + 1'b1;
                end else begin
                    m <= m + 1'b1;
                end
            end else begin
                n <= n + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mxm_operand_sequencer.sv
// Holds A (MxN) and X (NxP) and streams one (A,X) pair per cycle for the MxM_ReLu datapath.
//   state  | meaning
//   IDLE   | waiting for start; arrays writable, outputs zero
//   STREAM | one registered operand pair valid every cycle
//   FIN    | single-cycle done pulse after the last pair
module mxm_operand_sequencer
    import mxm_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int M = M_DEF,
    parameter int N = N_DEF,
    parameter int P = P_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    mxm_operand_sequencer_if.slave  bus
);
    localparam int AW   = addr_w(M, N, P);
    localparam int A_SZ = M * N;
    localparam int X_SZ = N * P;
    localparam int AAW  = idx_w(A_SZ);
    localparam int XAW  = idx_w(X_SZ);

    seq_state_t state_q, state_d;
    logic       issue;

    logic [idx_w(N)-1:0] cnt_n;
    logic [idx_w(M)-1:0] cnt_m;
    logic [idx_w(P)-1:0] cnt_p;
    logic                cnt_last;

    logic [W-1:0] a_mem [A_SZ];
    logic [W-1:0] x_mem [X_SZ];

    logic [W-1:0] a_q, x_q;
    logic         first_q, last_q;

    logic [AW:0]    wr_addr;
    logic           a_wr, x_wr;
    logic [AAW-1:0] a_rd_idx;
    logic [XAW-1:0] x_rd_idx;

    mxm_index_counter #(.M(M), .N(N), .P(P)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .en   (issue),
        .clr  (state_q == FIN),
        .n    (cnt_n),
        .m    (cnt_m),
        .p    (cnt_p),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A pair is issued on the start edge and on every STREAM edge until the last one is out.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    issue   = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_q) state_d = FIN;
                else        issue   = 1'b1;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Range check is done one bit wider than the bus so out-of-range addresses cannot alias.
    assign wr_addr = {1'b0, bus.load_addr};
    assign a_wr    = bus.load_we && (state_q != STREAM) && !bus.load_sel
                     && (wr_addr < (AW+1)'(A_SZ));
    assign x_wr    = bus.load_we && (state_q != STREAM) && bus.load_sel
                     && (wr_addr < (AW+1)'(X_SZ));

    always_ff @(posedge clk) begin
        if (a_wr) a_mem[bus.load_addr[AAW-1:0]] <= bus.load_data;
        if (x_wr) x_mem[bus.load_addr[XAW-1:0]] <= bus.load_data;
    end

    assign a_rd_idx = AAW'(cnt_m) * AAW'(N) + AAW'(cnt_n);
    assign x_rd_idx = XAW'(cnt_p) * XAW'(N) + XAW'(cnt_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            x_q     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            a_q     <= issue ? a_mem[a_rd_idx] : '0;
            x_q     <= issue ? x_mem[x_rd_idx] : '0;
            first_q <= issue && (cnt_n == '0);
            last_q  <= issue && cnt_last;
        end
    end

    assign bus.busy  = (state_q == STREAM);
    assign bus.valid = (state_q == STREAM);
    assign bus.done  = (state_q == FIN);
    assign bus.first = first_q;
    assign bus.last  = last_q;
    assign bus.A     = a_q;
    assign bus.X     = x_q;
endmodule
